// File: rtl/health_pkg.sv
// Shared types for the health display scheduler.
// Contents: display FSM state enum, view selector enum, BCD digit limit, and a
// helper mapping a saved view back to its SHOW state.
package health_pkg;

  typedef enum logic [2:0] {
    SHOW_PULSE,
    SHOW_REACT,
    HOLD,
    REACT_OVR,
    REACT_LINGER
  } disp_state_t;

  typedef enum logic {
    VIEW_PULSE,
    VIEW_REACT
  } view_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic disp_state_t view_state(input view_t v);
    return (v == VIEW_REACT) ? SHOW_REACT : SHOW_PULSE;
  endfunction

endpackage

// File: rtl/bcd_word_check.sv
// Combinational validity check of a 4-digit packed BCD word.
// Ports:
//   word  in  16  packed BCD {d3,d2,d1,d0}
//   valid out 1   1 when every nibble is <= 9
module bcd_word_check
  import health_pkg::*;
(
  input  logic [15:0] word,
  output logic        valid
);

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (word[4*i +: 4] > BCD_MAX) valid = 1'b0;
    end
  end

endmodule

// File: rtl/health_display_scheduler.sv
// Arbitrates the shared seven-segment datapath between the pulse monitor and
// the reaction timer: manual toggle, auto-rotation, freeze, and a forced
// reaction view while a test runs (plus a linger period afterwards).
// Ports:
//   clk, rst          1 kHz tick clock; synchronous active-low reset
//   auto_en           level, auto-rotate between views
//   mode_pb, hold_pb  single-cycle pulses: toggle view / toggle freeze
//   react_busy        level, reaction test in progress
//   react_d, pulse_d  BCD words from the measurement blocks
//   pulse_upd         pulse_d carries a new reading
//   d, src            registered display word and source (1 = reaction)
//   holding           1 while frozen
//   bcd_err           sticky flag for a pulse reading with a non-BCD nibble
module health_display_scheduler
  import health_pkg::*;
#(
  parameter int unsigned DWELL_TICKS  = 3000,
  parameter int unsigned LINGER_TICKS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        auto_en,
  input  logic        mode_pb,
  input  logic        hold_pb,
  input  logic        react_busy,
  input  logic [15:0] react_d,
  input  logic [15:0] pulse_d,
  input  logic        pulse_upd,
  output logic [15:0] d,
  output logic        src,
  output logic        holding,
  output logic        bcd_err
);

  localparam int unsigned DwellW  = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
  localparam int unsigned LingerW = (LINGER_TICKS > 1) ? $clog2(LINGER_TICKS) : 1;
  localparam logic [DwellW-1:0]  DwellLast  = DwellW'(DWELL_TICKS - 1);
  localparam logic [LingerW-1:0] LingerLast = LingerW'(LINGER_TICKS - 1);

  disp_state_t        state_q, state_d;
  view_t              saved_q, saved_d;
  logic [DwellW-1:0]  dwell_q, dwell_d;
  logic [LingerW-1:0] linger_q, linger_d;
  logic [15:0]        pulse_lat_q;
  logic [15:0]        d_d;
  logic               src_d, holding_d;
  logic               pulse_ok;
  view_t              cur_view;
  disp_state_t        other_state;

  bcd_word_check u_bcd_word_check (
    .word  (pulse_d),
    .valid (pulse_ok)
  );

  assign cur_view    = (state_q == SHOW_REACT) ? VIEW_REACT : VIEW_PULSE;
  assign other_state = (state_q == SHOW_REACT) ? SHOW_PULSE : SHOW_REACT;

  // Next state; priority react_busy > hold_pb > mode_pb > dwell expiry.
  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    dwell_d  = dwell_q;
    linger_d = linger_q;
    unique case (state_q)
      SHOW_PULSE, SHOW_REACT: begin
        if (react_busy) begin
          state_d = REACT_OVR;
          saved_d = cur_view;
          dwell_d = '0;
        end else if (hold_pb) begin
          state_d = HOLD;
          saved_d = cur_view;
          dwell_d = '0;
        end else if (mode_pb) begin
          state_d = other_state;
          dwell_d = '0;
        end else if (auto_en) begin
          if (dwell_q == DwellLast) begin
            state_d = other_state;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_q + DwellW'(1);
          end
        end else begin
          dwell_d = '0;
        end
      end
      HOLD: begin
        if (react_busy) begin
          state_d = REACT_OVR;
        end else if (hold_pb) begin
          state_d = view_state(saved_q);
          dwell_d = '0;
        end
      end
      REACT_OVR: begin
        if (!react_busy) begin
          state_d  = REACT_LINGER;
          linger_d = '0;
        end
      end
      REACT_LINGER: begin
        if (react_busy) begin
          state_d = REACT_OVR;
        end else if (linger_q == LingerLast) begin
          state_d = view_state(saved_q);
          dwell_d = '0;
        end else begin
          linger_d = linger_q + LingerW'(1);
        end
      end
      default: state_d = SHOW_PULSE;
    endcase
  end

  // Outputs follow the state being entered, so every change shows one cycle later.
  always_comb begin
    d_d       = d;
    src_d     = src;
    holding_d = 1'b0;
    unique case (state_d)
      SHOW_PULSE: begin
        d_d   = pulse_lat_q;
        src_d = 1'b0;
      end
      SHOW_REACT, REACT_OVR, REACT_LINGER: begin
        d_d   = react_d;
        src_d = 1'b1;
      end
      HOLD:    holding_d = 1'b1;  // d and src keep their value from entry
      default: begin
        d_d   = '0;
        src_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SHOW_PULSE;
      saved_q     <= VIEW_PULSE;
      dwell_q     <= '0;
      linger_q    <= '0;
      pulse_lat_q <= '0;
      d           <= '0;
      src         <= 1'b0;
      holding     <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      state_q  <= state_d;
      saved_q  <= saved_d;
      dwell_q  <= dwell_d;
      linger_q <= linger_d;
      d        <= d_d;
      src      <= src_d;
      holding  <= holding_d;
      if (pulse_upd) begin
        if (pulse_ok) pulse_lat_q <= pulse_d;
        else          bcd_err     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_health_display_scheduler.sv
module tb_health_display_scheduler;

  localparam int DW = 4;
  localparam int LT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        auto_en = 1'b0;
  logic        mode_pb = 1'b0;
  logic        hold_pb = 1'b0;
  logic        react_busy = 1'b0;
  logic [15:0] react_d = 16'h0000;
  logic [15:0] pulse_d = 16'h0000;
  logic        pulse_upd = 1'b0;
  logic [15:0] d;
  logic        src, holding, bcd_err;

  health_display_scheduler #(
    .DWELL_TICKS  (DW),
    .LINGER_TICKS (LT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .auto_en    (auto_en),
    .mode_pb    (mode_pb),
    .hold_pb    (hold_pb),
    .react_busy (react_busy),
    .react_d    (react_d),
    .pulse_d    (pulse_d),
    .pulse_upd  (pulse_upd),
    .d          (d),
    .src        (src),
    .holding    (holding),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model: phase 0 = normal viewing, 1 = test running, 2 = lingering.
  int          m_phase = 0;
  bit          m_frozen = 0;
  bit          m_view = 0;
  bit          m_saved = 0;
  int          m_shown = 0;   // cycles the current view has been on screen in auto mode
  int          m_linger = 0;
  logic [15:0] m_lat = 16'h0000;
  logic [15:0] e_d = 16'h0000;
  bit          e_src = 0;
  bit          e_hold = 0;
  bit          e_err = 0;

  function automatic bit is_bcd(input logic [15:0] w);
    for (int i = 0; i < 4; i++) if (w[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    logic [15:0] nlat;
    if (!rst) begin
      m_phase = 0; m_frozen = 0; m_view = 0; m_saved = 0; m_shown = 0; m_linger = 0;
      m_lat = 16'h0000; e_d = 16'h0000; e_src = 0; e_hold = 0; e_err = 0;
      return;
    end
    nlat = m_lat;
    if (pulse_upd) begin
      if (is_bcd(pulse_d)) nlat = pulse_d;
      else e_err = 1;
    end
    if (m_phase == 1) begin
      if (!react_busy) begin m_phase = 2; m_linger = 0; end
    end else if (m_phase == 2) begin
      if (react_busy) m_phase = 1;
      else if (m_linger == LT - 1) begin m_phase = 0; m_view = m_saved; m_shown = 0; end
      else m_linger++;
    end else if (m_frozen) begin
      if (react_busy) begin m_phase = 1; m_frozen = 0; end
      else if (hold_pb) begin m_frozen = 0; m_view = m_saved; m_shown = 0; end
    end else begin
      if (react_busy) begin m_phase = 1; m_saved = m_view; m_shown = 0; end
      else if (hold_pb) begin m_frozen = 1; m_saved = m_view; m_shown = 0; end
      else if (mode_pb) begin m_view = !m_view; m_shown = 0; end
      else if (auto_en) begin
        m_shown++;
        if (m_shown == DW) begin m_view = !m_view; m_shown = 0; end
      end else m_shown = 0;
    end
    if (m_phase != 0) begin
      e_d = react_d; e_src = 1; e_hold = 0;
    end else if (m_frozen) begin
      e_hold = 1;
    end else begin
      e_src = m_view; e_d = m_view ? react_d : m_lat; e_hold = 0;
    end
    m_lat = nlat;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("model_d", d, e_d);
      check("model_src", {15'd0, src}, {15'd0, e_src});
      check("model_holding", {15'd0, holding}, {15'd0, e_hold});
      check("model_bcd_err", {15'd0, bcd_err}, {15'd0, e_err});
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      mode_pb = 0; hold_pb = 0; pulse_upd = 0;
    end
  endtask

  task automatic lit(input string name, input logic [15:0] d_exp, input bit src_exp,
                     input bit hold_exp);
    check({name, "_d"}, d, d_exp);
    check({name, "_src"}, {15'd0, src}, {15'd0, src_exp});
    check({name, "_holding"}, {15'd0, holding}, {15'd0, hold_exp});
  endtask

  initial begin
    // Reset state
    rst = 0;
    step(2);
    lit("reset", 16'h0000, 0, 0);
    check("reset_bcd_err", {15'd0, bcd_err}, 16'd0);
    rst = 1;
    check_en = 1;
    react_d = 16'h1234;

    // Pulse latch latency and manual toggle
    pulse_d = 16'h0072; pulse_upd = 1;
    step(1); lit("upd_n1", 16'h0000, 0, 0);
    step(1); lit("upd_n2", 16'h0072, 0, 0);
    mode_pb = 1; step(1); lit("mode_react", 16'h1234, 1, 0);
    mode_pb = 1; step(1); lit("mode_pulse", 16'h0072, 0, 0);

    // Auto rotation, 4 cycles per view, mode_pb restarts the count
    auto_en = 1;
    step(3); lit("auto_a", 16'h0072, 0, 0);
    step(1); lit("auto_b", 16'h1234, 1, 0);
    step(3); lit("auto_c", 16'h1234, 1, 0);
    step(1); lit("auto_d", 16'h0072, 0, 0);
    step(2);
    mode_pb = 1; step(1); lit("auto_mode", 16'h1234, 1, 0);
    step(3); lit("auto_restart", 16'h1234, 1, 0);
    step(1); lit("auto_back", 16'h0072, 0, 0);
    auto_en = 0;

    // Freeze
    hold_pb = 1; step(1); lit("hold_on", 16'h0072, 0, 1);
    pulse_d = 16'h0080; pulse_upd = 1; step(2); lit("hold_frozen", 16'h0072, 0, 1);
    hold_pb = 1; step(1); lit("hold_off", 16'h0080, 0, 0);

    // Override from HOLD, then linger
    hold_pb = 1; step(1);
    react_busy = 1; step(1); lit("ovr_from_hold", 16'h1234, 1, 0);
    react_busy = 0;
    step(1); lit("linger_1", 16'h1234, 1, 0);
    step(1); lit("linger_2", 16'h1234, 1, 0);
    step(1); lit("linger_3", 16'h1234, 1, 0);
    step(1); lit("linger_done", 16'h0080, 0, 0);

    // Simultaneous events: override wins, buttons dropped
    react_busy = 1; hold_pb = 1; mode_pb = 1; step(1); lit("all_events", 16'h1234, 1, 0);
    react_busy = 0; step(4); lit("all_events_back", 16'h0080, 0, 0);

    // Non-BCD reading and reset during override
    pulse_d = 16'h00A5; pulse_upd = 1; step(2); lit("bad_bcd", 16'h0080, 0, 0);
    check("bad_bcd_err", {15'd0, bcd_err}, 16'd1);
    react_busy = 1; step(2);
    rst = 0; step(1); lit("mid_reset", 16'h0000, 0, 0);
    check("mid_reset_err", {15'd0, bcd_err}, 16'd0);
    rst = 1; react_busy = 0; step(1); lit("after_reset", 16'h0000, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 99) < 3) react_busy = !react_busy;
      if ($urandom_range(0, 99) < 2) auto_en = !auto_en;
      mode_pb = ($urandom_range(0, 99) < 6);
      hold_pb = ($urandom_range(0, 99) < 5);
      react_d = 16'($urandom);
      if ($urandom_range(0, 99) < 12) begin
        pulse_upd = 1;
        if ($urandom_range(0, 99) < 85)
          pulse_d = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        else
          pulse_d = 16'($urandom);
      end
      step(1);
    end

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
